// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI-lite read arbiter (AR + R channels).
// One outstanding transaction; grant held from AR issue to R handshake, round-robin on ties.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   own_arvalid;
    logic   own_rready;

    assign own_arvalid = owner_q ? m1_arvalid : m0_arvalid;
    assign own_rready  = owner_q ? m1_rready  : m0_rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                // Owner reset to 1 makes the first tie go to the IFU.
                if (m0_arvalid && m1_arvalid) begin
                    owner_d = ~owner_q;
                    state_d = ADDR;
                end else if (m0_arvalid) begin
                    owner_d = 1'b0;
                    state_d = ADDR;
                end else if (m1_arvalid) begin
                    owner_d = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (own_arvalid && s_arready) state_d = DATA;
            end
            DATA: begin
                if (s_rvalid && own_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_araddr   = owner_q ? m1_araddr : m0_araddr;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = s_rdata;
        m1_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m1_rresp   = s_rresp;
        busy       = (state_q != IDLE);
        grant      = owner_q;
        case (state_q)
            ADDR: begin
                s_arvalid  = own_arvalid;
                m0_arready = ~owner_q & s_arready;
                m1_arready =  owner_q & s_arready;
            end
            DATA: begin
                s_rready  = own_rready;
                m0_rvalid = ~owner_q & s_rvalid;
                m1_rvalid =  owner_q & s_rvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Two-master, one-slave arbiter for the AXI-lite read channel (AR + R). The instruction fetch unit (master 0) and the load/store unit (master 1) share a single memory read port through it. Only one transaction is outstanding at a time. The grant is held from AR issue until the R handshake completes. Requester selection is round-robin.

Parameters:
- ADDR_W, 32, address width of the araddr buses.
- DATA_W, 32, data width of the rdata buses.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_araddr  in  ADDR_W  IFU read address.
- m0_arvalid  in  1  IFU address valid.
- m0_arready  out  1  IFU address ready.
- m0_rdata  out  DATA_W  read data to IFU.
- m0_rresp  out  2  read response to IFU.
- m0_rvalid  out  1  read data valid to IFU.
- m0_rready  in  1  IFU ready for read data.
- m1_araddr, m1_arvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_rready: same directions, widths and meanings for the LSU.
- s_araddr  out  ADDR_W  address to memory.
- s_arvalid  out  1  address valid to memory.
- s_arready  in  1  memory address ready.
- s_rdata  in  DATA_W  read data from memory.
- s_rresp  in  2  read response from memory.
- s_rvalid  in  1  memory read data valid.
- s_rready  out  1  ready for read data, to memory.
- busy  out  1  high whenever state != IDLE.
- grant  out  1  current owner (0 = IFU, 1 = LSU); holds the last owner in IDLE.

Behaviour:
- States: IDLE, ADDR, DATA. A 2-bit state register plus a 1-bit owner register, both reset asynchronously.
- Reset values:
  - state = IDLE, owner = 1, so the IFU wins the first tie.
  - All valid and ready outputs are 0: s_arvalid, s_rready, m0/m1_arready, m0/m1_rvalid.
  - busy = 0, grant = 1.
- IDLE:
  - No handshake is passed through; all valid and ready outputs are 0.
  - If exactly one mN_arvalid is high, owner <= N and the next state is ADDR.
  - If both are high, owner <= ~owner (round-robin) and the next state is ADDR.
  - If neither is high, stay in IDLE.
  - Arbitration costs one cycle: a request is never accepted in the cycle it is first raised.
- ADDR:
  - s_araddr and s_arvalid are driven combinationally from the owner's araddr and arvalid.
  - owner_arready = s_arready; the non-owner's arready = 0.
  - On s_arvalid && s_arready, the next state is DATA.
- DATA:
  - s_rready = owner_rready.
  - owner_rvalid = s_rvalid; the non-owner's rvalid = 0.
  - s_rdata and s_rresp are broadcast to both mN_rdata/mN_rresp in every state; only rvalid is gated.
  - On s_rvalid && s_rready, the next state is IDLE.
  - A non-zero rresp still ends the transaction; it is forwarded unchanged.
- s_araddr in IDLE and DATA is driven from the owner register value, so it is a don't-care but stable.
- The non-owner's arvalid may stay high while it waits; it is served on the next IDLE arbitration.
  - Under continuous contention, grants strictly alternate: 0, 1, 0, 1, ...
- The owner deasserting arvalid in ADDR is an AXI violation: the arbiter stays in ADDR with s_arvalid = 0 and the grant held. No recovery is defined.
- Asynchronous reset mid-transaction returns immediately to IDLE with all outputs at their reset values. The in-flight slave transaction is abandoned; memory is reset by the same rst.
- Minimum turnaround per transaction with a zero-wait slave: IDLE → ADDR → DATA → IDLE, i.e. 3 cycles.

Test Plan:
- IFU only: m0_arvalid = 1 with araddr = 0x80000000; slave arready 1 cycle after s_arvalid, rdata = 0x00000413 two cycles later.
  - Required: m0_arready pulses once and m0_rvalid pulses with rdata 0x00000413.
  - m1_arready and m1_rvalid stay 0; busy is high for exactly the transaction; grant = 0.
- Simultaneous requests (m0 addr 0x80000004, m1 addr 0x80001000) held continuously for 4 transactions.
  - Required: s_araddr sequence is 0x80000004, 0x80001000, 0x80000004, 0x80001000.
  - Each master sees rvalid only for its own transaction.
- LSU request raised while IFU owns DATA state with the slave stalling rvalid for 5 cycles.
  - Required: m1_arready stays 0 throughout.
  - The LSU is granted in the IDLE cycle after IFU's R handshake; s_arvalid rises 1 cycle later.
- Owner backpressure: s_rvalid = 1 while m1_rready = 0 for 3 cycles, then 1.
  - Required: s_rready mirrors m1_rready, state stays DATA, and the transaction completes on the cycle m1_rready = 1.
- Error response: s_rresp = 2'b10 on the IFU read.
  - Required: m0_rresp = 2'b10 together with m0_rvalid; the arbiter returns to IDLE and serves the next request normally.
- Reset asserted asynchronously mid-cycle in ADDR state.
  - Required: s_arvalid, m0/m1_arready and busy drop to 0 without waiting for a clock edge.
  - After release, the first tie is granted to the IFU.
